// File: rtl/btn_event_avs.sv
// Push-button conditioner for the Nios system: 2-flop synchroniser, debounce FSM,
// edge capture, press counter and maskable level irq behind an Avalon-MM slave.
module btn_event_avs #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        btn_in,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int unsigned CNT_W  = 24;
    localparam int unsigned PCNT_W = 16;
    localparam int unsigned DATA_W = 32;

    // Counter value on the last qualifying cycle: the transition edge is the
    // DEBOUNCE_CYCLES-th consecutive cycle of a stable level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic             IDLE_LVL = BTN_ACTIVE_LOW;

    localparam logic [1:0] S_RELEASED        = 2'd0;
    localparam logic [1:0] S_CONFIRM_PRESS   = 2'd1;
    localparam logic [1:0] S_PRESSED         = 2'd2;
    localparam logic [1:0] S_CONFIRM_RELEASE = 2'd3;

    localparam logic [1:0] A_STATUS     = 2'd0;
    localparam logic [1:0] A_IRQ_MASK   = 2'd1;
    localparam logic [1:0] A_EDGE_CAP   = 2'd2;
    localparam logic [1:0] A_PRESS_CNT  = 2'd3;

    logic              r_sync1;
    logic              r_sync2;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_p;
    logic              w_press_evt;
    logic              w_level;
    logic              r_irq_mask;
    logic              w_irq_mask_nxt;
    logic              r_edge_cap;
    logic              w_edge_cap_nxt;
    logic [PCNT_W-1:0] r_press_cnt;
    logic [PCNT_W-1:0] w_press_cnt_nxt;
    logic [DATA_W-1:0] w_rd_mux;
    logic              w_wr_mask;
    logic              w_wr_ec;
    logic              w_wr_cnt;
    logic              w_unused_wdata;

    // Metastability filter; resets to the unpressed pin level
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= IDLE_LVL;
            r_sync2 <= IDLE_LVL;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_p     = r_sync2 ^ IDLE_LVL;
    assign w_level = (r_state == S_PRESSED) || (r_state == S_CONFIRM_RELEASE);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_RELEASED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_evt = 1'b0;
        case (r_state)
            S_RELEASED: begin
                if (w_p) begin
                    w_state_nxt = S_CONFIRM_PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            S_CONFIRM_PRESS: begin
                if (!w_p) begin
                    w_state_nxt = S_RELEASED;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_PRESSED;
                        w_press_evt = 1'b1;
                    end
                end
            end
            S_PRESSED: begin
                if (!w_p) begin
                    w_state_nxt = S_CONFIRM_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                if (w_p) begin
                    w_state_nxt = S_PRESSED;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_RELEASED;
                    end
                end
            end
        endcase
    end

    assign w_wr_mask      = avs_write && (avs_address == A_IRQ_MASK);
    assign w_wr_ec        = avs_write && (avs_address == A_EDGE_CAP);
    assign w_wr_cnt       = avs_write && (avs_address == A_PRESS_CNT);
    assign w_unused_wdata = ^avs_writedata[31:1];

    // Register next values; a press event beats a concurrent clear
    always_comb begin
        w_irq_mask_nxt  = r_irq_mask;
        w_edge_cap_nxt  = r_edge_cap;
        w_press_cnt_nxt = r_press_cnt;
        w_rd_mux        = '0;
        if (w_wr_mask) begin
            w_irq_mask_nxt = avs_writedata[0];
        end
        if (w_press_evt) begin
            w_edge_cap_nxt  = 1'b1;
            w_press_cnt_nxt = w_wr_cnt ? PCNT_W'(1) : r_press_cnt + PCNT_W'(1);
        end else begin
            if (w_wr_ec && avs_writedata[0]) begin
                w_edge_cap_nxt = 1'b0;
            end
            if (w_wr_cnt) begin
                w_press_cnt_nxt = '0;
            end
        end
        case (avs_address)
            A_STATUS:   w_rd_mux = DATA_W'(w_level);
            A_IRQ_MASK: w_rd_mux = DATA_W'(r_irq_mask);
            A_EDGE_CAP: w_rd_mux = DATA_W'(r_edge_cap);
            default:    w_rd_mux = DATA_W'(r_press_cnt);
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_irq_mask   <= 1'b0;
            r_edge_cap   <= 1'b0;
            r_press_cnt  <= '0;
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            r_irq_mask  <= w_irq_mask_nxt;
            r_edge_cap  <= w_edge_cap_nxt;
            r_press_cnt <= w_press_cnt_nxt;
            if (avs_read) begin
                avs_readdata <= w_rd_mux;
            end
            irq <= r_irq_mask & r_edge_cap;
        end
    end

endmodule

// File: tb/tb_btn_event_avs.sv
// Self-checking bench for btn_event_avs (DEBOUNCE_CYCLES=4, active-low button).
module tb_btn_event_avs;

    localparam int unsigned DC = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        btn_in;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    btn_event_avs #(.DEBOUNCE_CYCLES(DC), .BTN_ACTIVE_LOW(1'b1)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .btn_in        (btn_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    sb_t sb_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Read monitor: a read seen at a rising edge is compared on the next falling edge
    initial begin
        logic rd_seen;
        sb_t  e;
        forever begin
            @(posedge clk_clk);
            rd_seen = avs_read && reset_reset_n;
            @(negedge clk_clk);
            if (rd_seen) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: got read data 0x%08h, expected no read", avs_readdata);
                end else begin
                    e = sb_q.pop_front();
                    check(e.nm, avs_readdata, e.exp);
                end
            end
        end
    end

    task automatic step_idle();
        @(negedge clk_clk);
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_address   = 2'd0;
        avs_writedata = 32'd0;
    endtask

    task automatic step_rd(input logic [1:0] addr, input logic [31:0] exp, input string nm);
        @(negedge clk_clk);
        avs_read      = 1'b1;
        avs_write     = 1'b0;
        avs_address   = addr;
        avs_writedata = 32'd0;
        sb_q.push_back('{nm, exp});
    endtask

    task automatic step_wr(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk_clk);
        avs_read      = 1'b0;
        avs_write     = 1'b1;
        avs_address   = addr;
        avs_writedata = data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_idle();
    endtask

    // Press and hold long enough to qualify, then release and re-qualify
    task automatic press_release();
        step_idle();
        btn_in = 1'b0;
        idle(9);
        btn_in = 1'b1;
        idle(9);
    endtask

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reset_n = 1'b0;
        btn_in        = 1'b1;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;

        // Reset state
        repeat (3) @(negedge clk_clk);
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset_reset_n = 1'b1;
        idle(2);

        // Register access table
        vecs.push_back('{1'b1, 1'b0, 2'd0, 32'h0,        32'd0, "tbl_status_rst"});
        vecs.push_back('{1'b1, 1'b0, 2'd1, 32'h0,        32'd0, "tbl_mask_rst"});
        vecs.push_back('{1'b1, 1'b0, 2'd2, 32'h0,        32'd0, "tbl_ec_rst"});
        vecs.push_back('{1'b1, 1'b0, 2'd3, 32'h0,        32'd0, "tbl_cnt_rst"});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'hFFFFFFFF, 32'd0, ""});
        vecs.push_back('{1'b1, 1'b0, 2'd1, 32'h0,        32'd1, "tbl_mask_set"});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'hFFFFFFFE, 32'd0, ""});
        vecs.push_back('{1'b1, 1'b0, 2'd1, 32'h0,        32'd0, "tbl_mask_bit0_only"});
        vecs.push_back('{1'b1, 1'b1, 2'd1, 32'h1,        32'd0, "tbl_rdwr_prewrite"});
        vecs.push_back('{1'b1, 1'b0, 2'd1, 32'h0,        32'd1, "tbl_rdwr_written"});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 32'h0,        32'd0, ""});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 32'hFFFFFFFF, 32'd0, ""});
        vecs.push_back('{1'b1, 1'b0, 2'd0, 32'h0,        32'd0, "tbl_status_ro"});
        vecs.push_back('{1'b1, 1'b0, 2'd1, 32'h0,        32'd0, "tbl_mask_clr"});
        foreach (vecs[i]) begin
            @(negedge clk_clk);
            avs_read      = vecs[i].rd;
            avs_write     = vecs[i].wr;
            avs_address   = vecs[i].addr;
            avs_writedata = vecs[i].wdata;
            if (vecs[i].rd) sb_q.push_back('{vecs[i].nm, vecs[i].exp});
        end
        idle(2);

        // Clean press: STATUS rises exactly 2+DC cycles after the pin edge
        for (int j = 0; j < 10; j++) begin
            step_rd(2'd0, (j >= 6) ? 32'd1 : 32'd0, $sformatf("press_status_c%0d", j));
            if (j == 0) btn_in = 1'b0;
        end
        step_rd(2'd2, 32'd1, "press_ec");
        step_rd(2'd3, 32'd1, "press_cnt");
        step_idle();
        check("press_irq_masked", 32'(irq), 32'd0);
        btn_in = 1'b1;
        idle(9);
        step_rd(2'd0, 32'd0, "release_status");
        step_rd(2'd3, 32'd1, "release_no_event");

        // Bounce rejection
        step_wr(2'd2, 32'h1);
        step_wr(2'd3, 32'h0);
        step_idle();
        btn_in = 1'b0;
        idle(3);
        btn_in = 1'b1;
        idle(1);
        btn_in = 1'b0;
        idle(3);
        btn_in = 1'b1;
        idle(8);
        step_rd(2'd0, 32'd0, "bounce_status");
        step_rd(2'd3, 32'd0, "bounce_cnt");
        step_rd(2'd2, 32'd0, "bounce_ec");

        // Interrupt flow
        step_wr(2'd1, 32'h1);
        step_idle();
        btn_in = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            step_idle();
            check($sformatf("irq_rise_c%0d", j), 32'(irq), (j >= 7) ? 32'd1 : 32'd0);
        end
        step_wr(2'd2, 32'h0);
        step_idle();
        check("irq_w0_keep1", 32'(irq), 32'd1);
        step_idle();
        check("irq_w0_keep2", 32'(irq), 32'd1);
        step_wr(2'd2, 32'h1);
        step_idle();
        check("irq_clr_lat", 32'(irq), 32'd1);
        step_idle();
        check("irq_clr", 32'(irq), 32'd0);
        btn_in = 1'b1;
        idle(9);

        // Set/clear collision on EDGE_CAPTURE (mask=1, ec=0, count=1)
        step_idle();
        btn_in = 1'b0;
        idle(4);
        step_wr(2'd2, 32'h1);
        step_idle();
        check("coll_irq_c6", 32'(irq), 32'd0);
        step_idle();
        check("coll_irq_c7", 32'(irq), 32'd1);
        step_rd(2'd2, 32'd1, "coll_ec");
        step_idle();
        check("coll_irq_held", 32'(irq), 32'd1);
        btn_in = 1'b1;
        idle(9);
        step_rd(2'd3, 32'd2, "coll_cnt_pre");

        // Press coinciding with PRESS_COUNT clear
        step_idle();
        btn_in = 1'b0;
        idle(4);
        step_wr(2'd3, 32'hFFFFFFFF);
        idle(2);
        step_rd(2'd3, 32'd1, "cnt_coll");
        btn_in = 1'b1;
        idle(9);

        // Counter wrap and clear
        @(negedge clk_clk);
        force dut.r_press_cnt = 16'hFFFF;
        @(negedge clk_clk);
        release dut.r_press_cnt;
        step_rd(2'd3, 32'h0000FFFF, "wrap_preload");
        press_release();
        step_rd(2'd3, 32'd0, "wrap_zero");
        press_release();
        step_rd(2'd3, 32'd1, "wrap_next");
        step_wr(2'd3, 32'h12345678);
        step_rd(2'd3, 32'd0, "cnt_clear");

        // Reset during CONFIRM_PRESS with the button held
        step_rd(2'd1, 32'd1, "prerst_mask");
        step_idle();
        check("prerst_irq", 32'(irq), 32'd1);
        btn_in = 1'b0;
        idle(4);
        reset_reset_n = 1'b0;
        step_idle();
        check("midrst_readdata", avs_readdata, 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        for (int j = 0; j < 10; j++) begin
            if (j == 0) begin
                step_rd(2'd1, 32'd0, "postrst_mask");
                reset_reset_n = 1'b1;
            end else if (j == 1) begin
                step_rd(2'd2, 32'd0, "postrst_ec");
            end else if (j == 2) begin
                step_rd(2'd3, 32'd0, "postrst_cnt");
            end else begin
                step_rd(2'd0, (j >= 6) ? 32'd1 : 32'd0, $sformatf("postrst_status_c%0d", j));
            end
        end
        step_rd(2'd3, 32'd1, "postrst_press_cnt");
        step_idle();
        check("postrst_irq", 32'(irq), 32'd0);
        btn_in = 1'b1;
        idle(4);

        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_drain: got %0d pending reads, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
